// File: rtl/crc_ctrl_pkg.sv
// Shared definitions for the CRC frame controller: state encoding,
// default data width and the bit-index width helper.
package crc_ctrl_pkg;

  // Default byte / CRC width; matches the serial CRC engine.
  localparam int CRC_DATA_WIDTH = 8;

  // Width of a counter that indexes bits 0..w-1 of a w-bit word.
  function automatic int crc_idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CRC_IDX_WIDTH = crc_idx_width(CRC_DATA_WIDTH);

  // Controller states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEED    = 3'd1,
    SHIFT   = 3'd2,
    COLLECT = 3'd3,
    DONE    = 3'd4,
    DRAIN   = 3'd5
  } crc_state_e;

endpackage

// File: rtl/crc_bit_serializer.sv
// Byte-to-bit serializer: shift register, one-byte holding register,
// bit index and input-ready generation. Bytes leave LSB-first.
module crc_bit_serializer
  import crc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = CRC_DATA_WIDTH,
  parameter int IDX_W      = CRC_IDX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alive,
  input  logic                  idle,
  input  logic                  shifting,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  ser_bit,
  output logic                  idx_last,
  output logic                  cur_last,
  output logic                  byte_avail
);

  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  shift_last_reg;
  logic                  hold_last_reg;
  logic                  hold_full_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic                  xfer;

  // Once the current byte carries LAST nothing more is accepted for this frame.
  assign in_ready   = alive && (idle || (shifting && !hold_full_reg && !shift_last_reg));
  assign xfer       = in_valid && in_ready;
  assign idx_last   = shifting && (idx_reg == IDX_END);
  assign cur_last   = shift_last_reg;
  // A byte is ready for the next slot if it is held or arriving right now.
  assign byte_avail = hold_full_reg || xfer;
  assign ser_bit    = shifting ? shift_reg[idx_reg] : 1'b0;

  // Load, refill and bit-index sequencing of the datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg      <= '0;
      hold_reg       <= '0;
      shift_last_reg <= 1'b0;
      hold_last_reg  <= 1'b0;
      hold_full_reg  <= 1'b0;
      idx_reg        <= '0;
    end else if (idle) begin
      idx_reg       <= '0;
      hold_full_reg <= 1'b0;
      hold_last_reg <= 1'b0;
      if (xfer) begin
        shift_reg      <= in_data;
        shift_last_reg <= in_last;
      end
    end else if (shifting) begin
      if (idx_last) begin
        idx_reg <= '0;
        if (hold_full_reg) begin
          shift_reg      <= hold_reg;
          shift_last_reg <= hold_last_reg;
          hold_full_reg  <= 1'b0;
          hold_last_reg  <= 1'b0;
        end else if (xfer) begin
          // Byte arriving in the final-bit cycle goes straight to the shifter.
          shift_reg      <= in_data;
          shift_last_reg <= in_last;
        end
      end else begin
        idx_reg <= idx_reg + IDX_W'(1);
        if (xfer) begin
          hold_reg      <= in_data;
          hold_last_reg <= in_last;
          hold_full_reg <= 1'b1;
        end
      end
    end else begin
      idx_reg       <= '0;
      hold_full_reg <= 1'b0;
      hold_last_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/crc_frame_ctrl.sv
// CRC frame controller: reseeds the serial CRC engine per frame, streams
// frame bytes into it bit-serially and gathers the 8 result bits into a
// parallel word. Optional frame counter enabled by CRC_CTRL_FRAME_CNT_EN.
module crc_frame_ctrl
  import crc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = CRC_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  input  logic                  IN_LAST,
  output logic                  IN_READY,
  output logic                  ENG_RST_N,
  output logic                  ENG_ACTIVE,
  output logic                  ENG_DATA,
  input  logic                  ENG_CRC,
  input  logic                  ENG_VALID,
  output logic [DATA_WIDTH-1:0] CRC_OUT,
  output logic                  CRC_VALID,
`ifdef CRC_CTRL_FRAME_CNT_EN
  output logic                  ERR,
  output logic [CNT_WIDTH-1:0]  FRAME_CNT
`else
  output logic                  ERR
`endif
);

  localparam int IW = crc_idx_width(DATA_WIDTH);
  localparam logic [IW:0] CNT_END = (IW + 1)'(DATA_WIDTH);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_SEED    = SEED;
  localparam logic [2:0] S_SHIFT   = SHIFT;
  localparam logic [2:0] S_COLLECT = COLLECT;
  localparam logic [2:0] S_DONE    = DONE;
  localparam logic [2:0] S_DRAIN   = DRAIN;

  logic [2:0]            state_reg;
  logic [2:0]            state_next;
  logic [IW:0]           cnt_reg;
  logic [DATA_WIDTH-1:0] collect_reg;
  logic [DATA_WIDTH-1:0] crc_out_reg;
  logic                  eng_rst_n_reg;
  logic                  alive_reg;
  logic                  err_next;
  logic                  sample;
  logic                  xfer;
  logic                  ser_bit;
  logic                  idx_last;
  logic                  cur_last;
  logic                  byte_avail;

  crc_bit_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IW)
  ) u_ser (
    .clk        (CLK),
    .rst_n      (RST),
    .alive      (alive_reg),
    .idle       (state_reg == S_IDLE),
    .shifting   (state_reg == S_SHIFT),
    .in_data    (IN_DATA),
    .in_valid   (IN_VALID),
    .in_last    (IN_LAST),
    .in_ready   (IN_READY),
    .ser_bit    (ser_bit),
    .idx_last   (idx_last),
    .cur_last   (cur_last),
    .byte_avail (byte_avail)
  );

  assign xfer       = IN_VALID && IN_READY;
  // First COLLECT cycle (cnt 0) is the engine's register delay; no sample.
  assign sample     = (state_reg == S_COLLECT) && (cnt_reg != '0);
  assign ENG_ACTIVE = (state_reg == S_SHIFT);
  assign ENG_DATA   = ser_bit;
  assign ENG_RST_N  = eng_rst_n_reg;
  assign CRC_OUT    = crc_out_reg;
  assign CRC_VALID  = (state_reg == S_DONE);
  assign ERR        = err_next;

  // Next-state decode plus underrun / engine-protocol error detection.
  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    case (state_reg)
      S_IDLE:  if (xfer) state_next = S_SEED;
      S_SEED:  state_next = S_SHIFT;
      S_SHIFT: begin
        if (idx_last) begin
          if (cur_last) begin
            state_next = S_COLLECT;
          end else if (!byte_avail) begin
            err_next   = 1'b1;
            state_next = S_DRAIN;
          end
        end
      end
      S_COLLECT: begin
        if (sample) begin
          if (!ENG_VALID) begin
            err_next   = 1'b1;
            state_next = S_IDLE;
          end else if (cnt_reg == CNT_END) begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_DRAIN: if (cnt_reg == CNT_END) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, registered engine reset (low only during SEED) and post-reset enable.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= S_IDLE;
      eng_rst_n_reg <= 1'b0;
      alive_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      eng_rst_n_reg <= (state_next != S_SEED);
      alive_reg     <= 1'b1;
    end
  end

  // Cycle counter for COLLECT and DRAIN; restarts on every state change.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_reg <= '0;
    end else if ((state_next == state_reg) &&
                 ((state_reg == S_COLLECT) || (state_reg == S_DRAIN))) begin
      cnt_reg <= cnt_reg + (IW + 1)'(1);
    end else begin
      cnt_reg <= '0;
    end
  end

  // Gather serial CRC bits (first bit ends in bit 0); publish on the last sample.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      collect_reg <= '0;
      crc_out_reg <= '0;
    end else if (sample && ENG_VALID) begin
      collect_reg <= {ENG_CRC, collect_reg[DATA_WIDTH-1:1]};
      if (cnt_reg == CNT_END) begin
        crc_out_reg <= {ENG_CRC, collect_reg[DATA_WIDTH-1:1]};
      end
    end
  end

`ifdef CRC_CTRL_FRAME_CNT_EN
  logic [CNT_WIDTH-1:0] frame_cnt_reg;

  // Count completed frames; wraps naturally at all-ones.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frame_cnt_reg <= '0;
    end else if (state_reg == S_DONE) begin
      frame_cnt_reg <= frame_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign FRAME_CNT = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Testbench for crc_frame_ctrl with a behavioural serial CRC engine attached.
// Define CRC_CTRL_FRAME_CNT_EN to also exercise the frame counter (CNT_WIDTH=2).
module tb_crc_frame_ctrl;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       eng_rst_n, eng_active, eng_data, eng_crc, eng_valid;
  logic [7:0] crc_out;
  logic       crc_valid, err;
  logic       fault = 1'b0;
`ifdef CRC_CTRL_FRAME_CNT_EN
  logic [1:0] frame_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef CRC_CTRL_FRAME_CNT_EN
  crc_frame_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
`else
  crc_frame_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
`endif
    .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_LAST(in_last), .IN_READY(in_ready), .ENG_RST_N(eng_rst_n),
    .ENG_ACTIVE(eng_active), .ENG_DATA(eng_data), .ENG_CRC(eng_crc),
    .ENG_VALID(eng_valid), .CRC_OUT(crc_out), .CRC_VALID(crc_valid),
`ifdef CRC_CTRL_FRAME_CNT_EN
    .ERR(err), .FRAME_CNT(frame_cnt)
`else
    .ERR(err)
`endif
  );

  // Serial CRC-8 engine (poly 0x07, seed 0xD8): absorbs DATA while ACTIVE,
  // otherwise shifts its register out bit 0 first with Valid asserted.
  logic [7:0] em_crc;
  logic [2:0] em_idx;
  logic       em_bit, em_valid;
  always @(posedge clk) begin
    if (!eng_rst_n) begin
      em_crc <= 8'hD8; em_valid <= 1'b0; em_idx <= '0; em_bit <= 1'b0;
    end else if (eng_active) begin
      em_crc   <= {em_crc[6:0], 1'b0} ^ ((eng_data ^ em_crc[7]) ? 8'h07 : 8'h00);
      em_valid <= 1'b0; em_idx <= '0;
    end else begin
      em_bit <= em_crc[em_idx]; em_valid <= 1'b1; em_idx <= em_idx + 3'd1;
    end
  end
  assign eng_crc   = em_bit;
  assign eng_valid = em_valid && !fault;

  // Reference CRC: polynomial remainder of the LSB-first bit stream, seed 0xD8.
  function automatic logic [7:0] ref_crc(input bq_t q);
    logic [8:0] r;
    r = {1'b0, 8'hD8};
    foreach (q[k]) begin
      for (int i = 0; i < 8; i++) begin
        r = {r[7:0], 1'b0} ^ {8'h00, q[k][i] ^ r[7]} * 9'h107 ^ {r[7], 8'h00};
        r[8] = 1'b0;
      end
    end
    return r[7:0];
  endfunction

  // Per-frame observation results.
  int         r_xfer0, r_valid_cyc, r_nvalid, r_nerr, r_err_cyc, r_both;
  int         r_active_n, r_active_first, r_active_last, r_rstlow_n, r_ready_ret;
  logic [7:0] r_crc;
  bit         r_bits[$];
  logic [7:0] last_crc = 8'h00;
  int         good_frames = 0;

  // Offer the bytes back-to-back, optionally fault one COLLECT sample, and record what happens.
  task automatic run_frame(input bq_t bytes, input bit with_last, input int fault_at, input int window);
    int cyc = 0;
    int sent = 0;
    r_xfer0 = -1; r_valid_cyc = -1; r_nvalid = 0; r_nerr = 0; r_err_cyc = -1; r_both = 0;
    r_active_n = 0; r_active_first = -1; r_active_last = -1; r_rstlow_n = 0; r_ready_ret = -1;
    r_crc = 'x; r_bits.delete();
    repeat (window) begin
      @(negedge clk);
      if (sent < bytes.size()) begin
        in_valid = 1'b1; in_data = bytes[sent];
        in_last = with_last && (sent == bytes.size() - 1);
      end else begin
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'($urandom);
      end
      fault = (fault_at > 0) && (r_active_last >= 0) && (cyc == r_active_last + 1 + fault_at);
      #1;
      if (eng_active) begin
        r_bits.push_back(eng_data);
        if (r_active_first < 0) r_active_first = cyc;
        r_active_last = cyc; r_active_n++;
      end
      if (!eng_rst_n) r_rstlow_n++;
      if (crc_valid) begin r_nvalid++; if (r_valid_cyc < 0) r_valid_cyc = cyc; r_crc = crc_out; end
      if (err) begin r_nerr++; if (r_err_cyc < 0) r_err_cyc = cyc; end
      if (err && crc_valid) r_both++;
      if (in_ready && r_ready_ret < 0 &&
          ((r_err_cyc >= 0 && cyc > r_err_cyc) || (r_valid_cyc >= 0 && cyc > r_valid_cyc)))
        r_ready_ret = cyc;
      if (in_valid && in_ready) begin if (r_xfer0 < 0) r_xfer0 = cyc; sent++; end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; fault = 1'b0;
  endtask

  task automatic check_good_frame(input string name, input bq_t q);
    logic [7:0] exp_crc;
    int exp_lat;
    exp_crc = ref_crc(q);
    exp_lat = 1 + 8 * q.size() + 1 + 8 + 1;
    total++;
    if (r_nvalid !== 1 || r_crc !== exp_crc || r_nerr !== 0) begin
      bad++;
      $display("FAIL %s_crc: got crc=%02h valids=%0d errs=%0d want crc=%02h valids=1 errs=0",
               name, r_crc, r_nvalid, r_nerr, exp_crc);
    end
    total++;
    if (r_xfer0 < 0 || r_valid_cyc - r_xfer0 !== exp_lat) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d", name, r_valid_cyc - r_xfer0, exp_lat);
    end
    total++;
    if (r_active_n !== 8 * q.size() || r_active_last - r_active_first + 1 !== 8 * q.size()) begin
      bad++;
      $display("FAIL %s_active: got count=%0d span=%0d want %0d", name, r_active_n,
               r_active_last - r_active_first + 1, 8 * q.size());
    end
    total++;
    if (r_ready_ret - r_valid_cyc !== 1) begin
      bad++;
      $display("FAIL %s_ready_after_done: got %0d want 1", name, r_ready_ret - r_valid_cyc);
    end
    last_crc = exp_crc;
    good_frames++;
    $display("frame %s: bytes=%0d crc=%02h latency=%0d", name, q.size(), r_crc, r_valid_cyc - r_xfer0);
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if (in_ready !== 1'b0 || eng_rst_n !== 1'b0 || eng_active !== 1'b0 || eng_data !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got rdy=%b rstn=%b act=%b dat=%b want 0000", in_ready, eng_rst_n, eng_active, eng_data);
    end
    total++;
    if (crc_out !== 8'h00 || crc_valid !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: got crc=%02h v=%b e=%b want 00 0 0", crc_out, crc_valid, err);
    end
`ifdef CRC_CTRL_FRAME_CNT_EN
    total++;
    if (frame_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
`endif
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    total++;
    if (eng_rst_n !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: got rstn=%b rdy=%b want 1 1", eng_rst_n, in_ready);
    end
    last_crc = 8'h00; good_frames = 0;
    $display("reset: checked reset values and release");
  endtask

  task automatic test_single;
    bq_t q;
    logic [7:0] b;
    int errs;
    q = '{8'hA5};
    run_frame(q, 1'b1, 0, 40);
    total++;
    if (r_rstlow_n !== 1) begin bad++; $display("FAIL single_seed: got low=%0d want 1", r_rstlow_n); end
    b = 8'hA5; errs = 0;
    for (int i = 0; i < 8; i++) if (i >= r_bits.size() || r_bits[i] !== b[i]) errs++;
    total++;
    if (errs != 0 || r_bits.size() != 8) begin
      bad++; $display("FAIL single_bits: got %0d wrong of %0d bits want 0 wrong of 8", errs, r_bits.size());
    end
    check_good_frame("single_a5", q);
  endtask

  task automatic test_back_to_back;
    bq_t q;
    q = '{8'h01, 8'h02, 8'h03};
    run_frame(q, 1'b1, 0, 60);
    check_good_frame("b2b", q);
  endtask

  task automatic test_random_frames;
    bq_t q;
    for (int f = 0; f < 6; f++) begin
      q.delete();
      repeat ($urandom_range(1, 4)) q.push_back(8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(q, 1'b1, 0, 8 * q.size() + 30);
      check_good_frame($sformatf("rand%0d", f), q);
    end
  endtask

  task automatic test_underrun;
    bq_t q;
    q = '{8'h11};
    run_frame(q, 1'b0, 0, 40);
    total++;
    if (r_nerr !== 1 || r_err_cyc - r_xfer0 !== 9 || r_both !== 0) begin
      bad++; $display("FAIL underrun_err: got errs=%0d at=%0d want 1 at 9", r_nerr, r_err_cyc - r_xfer0);
    end
    total++;
    if (r_nvalid !== 0 || crc_out !== last_crc) begin
      bad++; $display("FAIL underrun_novalid: got valids=%0d crc=%02h want 0 %02h", r_nvalid, crc_out, last_crc);
    end
    total++;
    if (r_ready_ret - r_err_cyc !== 10) begin
      bad++; $display("FAIL underrun_drain: got ready after %0d want 10", r_ready_ret - r_err_cyc);
    end
    $display("underrun: err at %0d ready back after %0d", r_err_cyc - r_xfer0, r_ready_ret - r_err_cyc);
  endtask

  task automatic test_engine_fault;
    bq_t q;
    q = '{8'($urandom)};
    run_frame(q, 1'b1, 3, 40);
    total++;
    if (r_nerr !== 1 || r_err_cyc - r_xfer0 !== 13 || r_nvalid !== 0) begin
      bad++; $display("FAIL fault_err: got errs=%0d at=%0d valids=%0d want 1 at 13 valids 0",
                      r_nerr, r_err_cyc - r_xfer0, r_nvalid);
    end
    total++;
    if (crc_out !== last_crc) begin
      bad++; $display("FAIL fault_hold: got crc=%02h want %02h", crc_out, last_crc);
    end
    $display("engine fault: err at %0d crc held %02h", r_err_cyc - r_xfer0, crc_out);
  endtask

  task automatic test_reset_mid;
    bq_t q;
    int act = 0;
    bit hit = 0;
    bit xfered = 0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clk);
      in_valid = !xfered; in_data = 8'hA5; in_last = 1'b1;
      #1;
      if (in_valid && in_ready) xfered = 1;
      if (eng_active) begin
        act++;
        if (act == 5) begin
          rst = 1'b0; #1; hit = 1;
          total++;
          if ({in_ready, eng_rst_n, eng_active, eng_data, crc_valid, err} !== 6'b0 || crc_out !== 8'h00) begin
            bad++; $display("FAIL midreset_vals: got rdy=%b rstn=%b act=%b dat=%b v=%b e=%b crc=%02h want all 0",
                            in_ready, eng_rst_n, eng_active, eng_data, crc_valid, err, crc_out);
          end
        end
      end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL midreset_reach: got no bit-4 cycle want reached"); end
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    last_crc = 8'h00; good_frames = 0;
    q = '{8'hA5};
    run_frame(q, 1'b1, 0, 40);
    check_good_frame("after_reset", q);
  endtask

`ifdef CRC_CTRL_FRAME_CNT_EN
  task automatic test_frame_cnt;
    bq_t q;
    test_reset();
    for (int f = 0; f < 5; f++) begin
      q.delete(); q.push_back(8'($urandom));
      run_frame(q, 1'b1, 0, 40);
      check_good_frame($sformatf("cnt%0d", f), q);
    end
    total++;
    if (frame_cnt !== 2'(good_frames % 4)) begin
      bad++; $display("FAIL cnt_wrap: got %0d want %0d", frame_cnt, good_frames % 4);
    end
    q = '{8'h5A};
    run_frame(q, 1'b0, 0, 40);
    total++;
    if (frame_cnt !== 2'(good_frames % 4)) begin
      bad++; $display("FAIL cnt_err: got %0d want %0d", frame_cnt, good_frames % 4);
    end
    $display("frame counter: %0d after %0d good frames and one underrun", frame_cnt, good_frames);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random_frames();
    test_underrun();
    test_engine_fault();
    test_random_frames();
    test_reset_mid();
`ifdef CRC_CTRL_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
